memory_bank: RTL

- Parametrised multi-word storage bank; successor to the single-word gated-latch storage.
- Generalised to DEPTH words of WIDTH bits, and made fully synchronous and clocked.
- Has one write port and two independent registered read ports, with write-first bypass.
- A sequenced bulk-clear engine zeroes one word per cycle; it sits beside the datapath as a small register file.

---
 rtl/memory_bank.sv | 114 +++++++++++
 1 files changed

// File: rtl/memory_bank.sv
// Synchronous DEPTH x WIDTH storage bank: one write port, two registered read ports with
// write-first bypass, and a sequenced bulk-clear engine that zeroes one word per cycle.
module memory_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en_a,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  output logic [WIDTH-1:0]  o_rd_data_a,
  output logic              o_rd_valid_a,
  input  logic              i_rd_en_b,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [WIDTH-1:0]  o_rd_data_b,
  output logic              o_rd_valid_b,
  input  logic              i_clear,
  output logic              o_busy
);

  typedef enum logic {StIdle, StClear} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic                w_clearing;
  logic                w_ptr_last;
  logic [WIDTH-1:0]    w_rd_word_a;
  logic [WIDTH-1:0]    w_rd_word_b;

  assign w_ptr_last = (r_ptr == ADDR_W'(DEPTH - 1));

  // Clear FSM: state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_clear) w_state_next = StClear;
      StClear: if (w_ptr_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    w_clearing = (r_state == StClear);
    o_busy     = w_clearing;
  end

  // Pointer rests at zero in idle so a new clear always starts from word 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_clearing && !w_ptr_last) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end else begin
      r_ptr <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clearing) begin
      r_mem[r_ptr] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    w_rd_word_a = r_mem[i_rd_addr_a];
    w_rd_word_b = r_mem[i_rd_addr_b];
    if (i_wr_en && (i_wr_addr == i_rd_addr_a)) w_rd_word_a = i_wr_data;
    if (i_wr_en && (i_wr_addr == i_rd_addr_b)) w_rd_word_b = i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rd_data_a  <= '0;
      o_rd_valid_a <= 1'b0;
    end else begin
      o_rd_valid_a <= i_rd_en_a && !w_clearing;
      if (i_rd_en_a && !w_clearing) o_rd_data_a <= w_rd_word_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rd_data_b  <= '0;
      o_rd_valid_b <= 1'b0;
    end else begin
      o_rd_valid_b <= i_rd_en_b && !w_clearing;
      if (i_rd_en_b && !w_clearing) o_rd_data_b <= w_rd_word_b;
    end
  end

endmodule
